// File: rtl/data_mem_responder.sv
// data_mem_responder: pipeline data-memory responder driving a wait-stated SRAM port and the IP register port.
// Define MEM_RESP_ALIGN_CHK_EN to reject misaligned memory requests with an err pulse instead of accessing SRAM.
module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ena,
  input  logic              req_rw,
  input  logic [19:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_ip,
  output logic              stall,
  output logic              ack,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [17:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ip_we,
  output logic [3:0]        ip_addr,
  output logic [DATA_W-1:0] ip_wdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, IPWR, DONE} state_t;
  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                rd_q;
  logic                mem_cs_q, mem_we_q, ip_we_q, ack_q, rvalid_q;
  logic [DATA_W-1:0]   rdata_q, mem_wdata_q, ip_wdata_q;
  logic [17:0]         mem_addr_q;
  logic [3:0]          ip_addr_q;
`ifdef MEM_RESP_ALIGN_CHK_EN
  logic                err_q;
  logic                mis;
  assign mis = |req_addr[1:0];
  assign err = err_q;
`else
  logic                unused_low_addr;
  assign unused_low_addr = ^req_addr[1:0];
  assign err = 1'b0;
`endif
  assign stall     = req_ena & ~ack_q;
  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ip_we     = ip_we_q;
  assign ip_addr   = ip_addr_q;
  assign ip_wdata  = ip_wdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      ip_we_q     <= 1'b0;
      ack_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ip_addr_q   <= '0;
      ip_wdata_q  <= '0;
`ifdef MEM_RESP_ALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      ip_we_q  <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHK_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: if (req_ena) begin
          if (req_ip) begin
            ip_addr_q  <= req_addr[5:2];
            ip_wdata_q <= req_wdata;
            ip_we_q    <= 1'b1;
            state_q    <= IPWR;
          end
`ifdef MEM_RESP_ALIGN_CHK_EN
          else if (mis) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end
`endif
          else begin
            mem_addr_q  <= req_addr[19:2];
            mem_wdata_q <= req_wdata;
            rd_q        <= ~req_rw;
            cnt_q       <= 4'(WAIT_CYCLES);
            mem_cs_q    <= 1'b1;
            mem_we_q    <= req_rw;
            state_q     <= ACCESS;
          end
        end
        // mem_rdata is captured on the same edge that closes the access window
        ACCESS: if (cnt_q == 4'd0) begin
          mem_cs_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (rd_q) rdata_q <= mem_rdata;
          ack_q    <= 1'b1;
          rvalid_q <= rd_q;
          state_q  <= DONE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        IPWR: begin
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: cycle-indexed transaction model plus directed vectors for data_mem_responder.
module tb_data_mem_responder;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic req_ena = 0, req_rw = 0, req_ip = 0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_wdata = '0, mem_rdata = '0;
  logic stall, ack, rvalid, err, mem_cs, mem_we, ip_we;
  logic [31:0] rdata, mem_wdata, ip_wdata;
  logic [17:0] mem_addr;
  logic [3:0] ip_addr;
  logic b_ena = 0;
  logic [19:0] b_addr = '0;
  logic [31:0] b_mrd = '0;
  logic b_stall, b_ack, b_rvalid, b_err, b_cs, b_we, b_ipwe;
  logic [31:0] b_rdata, b_mwd, b_ipwd;
  logic [17:0] b_maddr;
  logic [3:0] b_ipa;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.WAIT_CYCLES(W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_ena(req_ena), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ip(req_ip), .stall(stall), .ack(ack), .rvalid(rvalid),
    .rdata(rdata), .err(err), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ip_we(ip_we), .ip_addr(ip_addr),
    .ip_wdata(ip_wdata));
  data_mem_responder #(.WAIT_CYCLES(0), .DATA_W(32)) u0 (
    .clk(clk), .rst(rst), .req_ena(b_ena), .req_rw(1'b0), .req_addr(b_addr),
    .req_wdata(32'h0), .req_ip(1'b0), .stall(b_stall), .ack(b_ack), .rvalid(b_rvalid),
    .rdata(b_rdata), .err(b_err), .mem_cs(b_cs), .mem_we(b_we), .mem_addr(b_maddr),
    .mem_wdata(b_mwd), .mem_rdata(b_mrd), .ip_we(b_ipwe), .ip_addr(b_ipa),
    .ip_wdata(b_ipwd));
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask
  // Model: each transaction is a start cycle t0 plus a length; outputs follow from k = cycle - t0.
  int cyc = 0, t0 = 0, len = 0, k;
  logic act = 0, m_ip = 0, m_rw = 0, m_mis = 0;
  logic [17:0] e_ma = '0;
  logic [31:0] e_mwd = '0, e_rd = '0, e_ipd = '0;
  logic [3:0] e_ipa = '0;
  logic mem_op, e_cs, e_ack;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      act = 0; e_ma = '0; e_mwd = '0; e_rd = '0; e_ipd = '0; e_ipa = '0;
      cmp("rst_cs", {31'b0, mem_cs}, 0);
      cmp("rst_we", {31'b0, mem_we}, 0);
      cmp("rst_ipwe", {31'b0, ip_we}, 0);
      cmp("rst_ack", {31'b0, ack}, 0);
      cmp("rst_rvalid", {31'b0, rvalid}, 0);
      cmp("rst_err", {31'b0, err}, 0);
      cmp("rst_rdata", rdata, 0);
      cmp("rst_maddr", {14'b0, mem_addr}, 0);
      cmp("rst_ipaddr", {28'b0, ip_addr}, 0);
      cmp("rst_stall", {31'b0, stall}, {31'b0, req_ena});
    end else begin
      if (act && cyc > t0 + len) act = 0;
      k = act ? cyc - t0 : 0;
      mem_op = act && !m_ip && !m_mis;
      e_cs = mem_op && k >= 1 && k <= W + 1;
      e_ack = act && k == len;
      cmp("mem_cs", {31'b0, mem_cs}, {31'b0, e_cs});
      cmp("mem_we", {31'b0, mem_we}, {31'b0, e_cs & m_rw});
      cmp("ip_we", {31'b0, ip_we}, {31'b0, act && m_ip && k == 1});
      cmp("ack", {31'b0, ack}, {31'b0, e_ack});
      cmp("rvalid", {31'b0, rvalid}, {31'b0, e_ack && mem_op && !m_rw});
      cmp("err", {31'b0, err}, {31'b0, e_ack && m_mis});
      cmp("stall", {31'b0, stall}, {31'b0, req_ena && !e_ack});
      cmp("rdata", rdata, e_rd);
      cmp("mem_addr", {14'b0, mem_addr}, {14'b0, e_ma});
      cmp("mem_wdata", mem_wdata, e_mwd);
      cmp("ip_addr", {28'b0, ip_addr}, {28'b0, e_ipa});
      cmp("ip_wdata", ip_wdata, e_ipd);
      if (mem_op && k == W + 1 && !m_rw) e_rd = mem_rdata;
      if (!act && req_ena) begin
        act = 1; t0 = cyc; m_ip = req_ip; m_rw = req_rw;
`ifdef MEM_RESP_ALIGN_CHK_EN
        m_mis = !req_ip && req_addr[1:0] != 2'b00;
`else
        m_mis = 0;
`endif
        len = m_ip ? 2 : m_mis ? 1 : W + 2;
        if (m_ip) begin e_ipa = req_addr[5:2]; e_ipd = req_wdata; end
        else if (!m_mis) begin e_ma = req_addr[19:2]; e_mwd = req_wdata; end
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic run_req(input logic ip, input logic rw, input logic [19:0] a,
                         input logic [31:0] wd, input logic [31:0] rd_in,
                         output int ack_at, output logic [15:0] cs_m,
                         output logic [15:0] stall_m, output logic [15:0] ipwe_m,
                         output logic rv, output logic er);
    req_ip = ip; req_rw = rw; req_addr = a; req_wdata = wd; mem_rdata = rd_in; req_ena = 1;
    ack_at = -1; cs_m = '0; stall_m = '0; ipwe_m = '0; rv = 0; er = 0;
    for (int c = 0; c < 12 && ack_at < 0; c++) begin
      @(negedge clk);
      cs_m[c] = mem_cs; stall_m[c] = stall; ipwe_m[c] = ip_we;
      if (ack) begin ack_at = c; rv = rvalid; er = err; end
      tick();
    end
    req_ena = 0;
    if (ack_at < 0) cmp("ack_timeout", 0, 1);
  endtask
  int at;
  logic [15:0] csm, stm, ipm, backm, bcsm;
  logic rv, er;
  initial begin
    repeat (2) tick();
    cmp("lit_reset_cs", {31'b0, mem_cs}, 0);
    cmp("lit_reset_rdata", rdata, 0);
    rst = 0;
    tick();
    run_req(0, 0, 20'h00104, 32'h0, 32'hDEADBEEF, at, csm, stm, ipm, rv, er);
    cmp("lit_rd_ack_cycle", at, 4);
    cmp("lit_rd_cs_mask", {16'b0, csm}, 32'h000E);
    cmp("lit_rd_stall_mask", {16'b0, stm}, 32'h000F);
    cmp("lit_rd_rvalid", {31'b0, rv}, 1);
    cmp("lit_rd_maddr", {14'b0, mem_addr}, 32'h00041);
    cmp("lit_rd_rdata", rdata, 32'hDEADBEEF);
    run_req(0, 1, 20'h00010, 32'h12345678, 32'hFFFF0000, at, csm, stm, ipm, rv, er);
    cmp("lit_wr_ack_cycle", at, 4);
    cmp("lit_wr_cs_mask", {16'b0, csm}, 32'h000E);
    cmp("lit_wr_rvalid", {31'b0, rv}, 0);
    cmp("lit_wr_wdata", mem_wdata, 32'h12345678);
    cmp("lit_wr_rdata_held", rdata, 32'hDEADBEEF);
    run_req(1, 0, 20'h0000C, 32'hA5, 32'h0, at, csm, stm, ipm, rv, er);
    cmp("lit_ip_ack_cycle", at, 2);
    cmp("lit_ip_we_mask", {16'b0, ipm}, 32'h0002);
    cmp("lit_ip_cs_mask", {16'b0, csm}, 0);
    cmp("lit_ip_addr", {28'b0, ip_addr}, 32'h3);
    cmp("lit_ip_wdata", ip_wdata, 32'hA5);
    b_addr = 20'h00008; b_mrd = 32'hCAFE0001; b_ena = 1; backm = '0; bcsm = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      backm[c] = b_ack; bcsm[c] = b_cs;
      if (c == 3) cmp("lit_b2b_rdata1", b_rdata, 32'hCAFE0001);
      if (c == 6) cmp("lit_b2b_rdata2", b_rdata, 32'hCAFE0002);
      tick();
      if (c == 2) begin b_addr = 20'h0000C; b_mrd = 32'hCAFE0002; end
      if (c == 5) b_ena = 0;
    end
    cmp("lit_b2b_ack_mask", {16'b0, backm}, 32'h0024);
    cmp("lit_b2b_cs_mask", {16'b0, bcsm}, 32'h0012);
    cmp("lit_b2b_maddr", {14'b0, b_maddr}, 32'h00003);
    req_ip = 0; req_rw = 0; req_addr = 20'h00104; mem_rdata = 32'h55555555; req_ena = 1;
    tick();
    tick();
    rst = 1; req_ena = 0;
    #1 cmp("lit_rst_cs_now", {31'b0, mem_cs}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp("lit_rst_no_ack", {31'b0, ack}, 0);
      cmp("lit_rst_cs_low", {31'b0, mem_cs}, 0);
      tick();
    end
    cmp("lit_rst_rdata", rdata, 0);
    rst = 0;
    tick();
    run_req(0, 0, 20'h00200, 32'h0, 32'h11112222, at, csm, stm, ipm, rv, er);
    cmp("lit_post_rst_ack", at, 4);
    cmp("lit_post_rst_rdata", rdata, 32'h11112222);
    run_req(0, 0, 20'h00102, 32'h0, 32'h77778888, at, csm, stm, ipm, rv, er);
`ifdef MEM_RESP_ALIGN_CHK_EN
    cmp("lit_mis_ack_cycle", at, 1);
    cmp("lit_mis_err", {31'b0, er}, 1);
    cmp("lit_mis_cs_mask", {16'b0, csm}, 0);
    cmp("lit_mis_rdata_held", rdata, 32'h11112222);
`else
    cmp("lit_mis_ack_cycle", at, 4);
    cmp("lit_mis_err", {31'b0, er}, 0);
    cmp("lit_mis_maddr", {14'b0, mem_addr}, 32'h00040);
    cmp("lit_mis_rdata", rdata, 32'h77778888);
`endif
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the pipeline data-memory request interface. Accepts a request from the ID/EX pipeline register (enable, read/write, 20-bit byte address, IP-write flag) and executes it. Memory accesses run against a synchronous SRAM port with programmable wait states; IP-register writes go to the peripheral IP register port. The block stalls the pipeline until the access completes and returns read data with a one-cycle valid pulse.

## Interface
- WAIT_CYCLES, 2: extra SRAM access cycles, range 0..15.
- DATA_W, 32: data width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_ena  in  1  request valid; held stable by the pipeline while stall=1.
- req_rw  in  1  1=write, 0=read.
- req_addr  in  20  byte address.
- req_wdata  in  DATA_W  write data.
- req_ip  in  1  1=write to IP register space; req_rw is ignored.
- stall  out  1  combinational: req_ena & ~ack.
- ack  out  1  one-cycle completion pulse; asserted in state DONE.
- rvalid  out  1  one-cycle pulse in DONE for a completed memory read.
- rdata  out  DATA_W  last read data; holds until the next read completes.
- err  out  1  misalignment pulse in DONE; constant 0 unless the config macro is defined.
- mem_cs, mem_we  out  1  SRAM chip select and write enable (registered).
- mem_addr  out  18  req_addr[19:2], latched.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  SRAM read data, sampled on the last ACCESS edge.
- ip_we  out  1  IP register write strobe, one cycle.
- ip_addr  out  4  req_addr[5:2], latched.
- ip_wdata  out  DATA_W  latched write data.

## Operation
- States: IDLE, ACCESS, IPWR, DONE; 4-bit wait counter cnt.
- IDLE & req_ena & req_ip: latch addr/wdata; go to IPWR.
- IDLE & req_ena & ~req_ip: latch addr/rw/wdata; cnt<=WAIT_CYCLES; mem_cs<=1; mem_we<=req_rw; go to ACCESS.
- ACCESS: if cnt==0, then mem_cs<=0, mem_we<=0, rdata<=mem_rdata if read, and go to DONE; else cnt<=cnt-1.
- IPWR: ip_we=1 for exactly this cycle; go to DONE.
- DONE: ack=1; rvalid=1 only if the op was a memory read; go to IDLE unconditionally.
- If req_ena drops mid-operation, the access still completes and ack still pulses. stall follows req_ena combinationally.
- Reset (asynchronous, any state): state=IDLE; cnt, mem_cs, mem_we, ip_we, ack, rvalid, err=0; rdata, mem_addr, mem_wdata, ip_addr, ip_wdata=0. An in-flight access is abandoned and no ack is issued.

## Timing
- Request first seen in IDLE (cycle 0). Memory op: ACCESS occupies cycles 1..WAIT_CYCLES+1; DONE/ack in cycle WAIT_CYCLES+2.
- IP write: IPWR in cycle 1, ack in cycle 2.
- stall is high from cycle 0 until the cycle before ack; it is low in the ack cycle, and the pipeline advances at the end of that cycle.
- Back-to-back requests: the next request is seen in IDLE the cycle after DONE, giving a minimum issue interval of WAIT_CYCLES+3 cycles for memory ops and 3 cycles for IP writes.
- mem_cs stays high for exactly WAIT_CYCLES+1 consecutive cycles per memory access.

## Configuration
- MEM_RESP_ALIGN_CHK_EN defined: in IDLE, a non-IP request with req_addr[1:0]!=0 goes directly to DONE. There is no mem_cs and no ip_we; err=1 and ack=1 in DONE (cycle 1); rvalid=0; rdata unchanged.
- Not defined: err is tied to 0, req_addr[1:0] is ignored, and all non-IP requests access SRAM.

## Test plan
- Read, WAIT_CYCLES=2, req_addr=20'h00104, mem_rdata=32'hDEADBEEF -> mem_addr=18'h00041; mem_cs high in cycles 1-3; ack and rvalid in cycle 4; rdata=32'hDEADBEEF; stall high in cycles 0-3.
- Write, req_addr=20'h00010, wdata=32'h12345678 -> mem_we=1 with mem_cs in cycles 1-3; ack in cycle 4; rvalid=0; rdata unchanged.
- IP write, req_ip=1, req_rw=0, req_addr=20'h0000C, wdata=32'hA5 -> ip_we=1 in cycle 1 only, ip_addr=4'h3, ip_wdata=32'hA5; ack in cycle 2; mem_cs never asserted.
- Two reads held back-to-back with WAIT_CYCLES=0 -> ack in cycles 2 and 5; each mem_cs lasts 1 cycle; rdata updates after each DONE.
- rst asserted in cycle 2 of a WAIT_CYCLES=2 read -> mem_cs drops immediately and stays low; no ack; rdata=0; after release, a new request completes normally.
- With MEM_RESP_ALIGN_CHK_EN, read at req_addr=20'h00102 -> err and ack in cycle 1; mem_cs stays 0. Without the macro -> normal access to mem_addr=18'h00040.
